memory_writeback: RTL
=====================

// Module: memory_writeback
// PURPOSE
// - Stage directly downstream of the execute pipeline register. Consumes its stored data, instruction,
//   store operand, r_abs, RFlags and reset_regs; performs data-memory load/store via req/ack handshake.
// - Commits results to register file, abs-register port and architectural flags; stalls upstream while waiting.
// PARAMETERS
// - DWIDTH   32  data/instruction width
// - AWIDTH   16  data-memory address width (address = in_data[AWIDTH-1:0])
// - TIMEOUT  15  max cycles to wait for mem_ack before abort (>=1)
// PORTS
// - clk           in   1       clock
// - rst           in   1       reset, asynchronous, active-high
// - in_valid      in   1       execute-stage outputs valid this cycle
// - in_data       in   DWIDTH  ALU result / memory address
// - in_instr      in   DWIDTH  instruction; opcode [31:27], rd [26:22]
// - in_register   in   DWIDTH  store operand
// - in_r_abs      in   DWIDTH  abs-register value
// - in_flags      in   7       {error,collision,between,below,equal,above,overflow}
// - in_reset_regs in   1       clear-registers request
// - stall         out  1       upstream must hold all in_* while high
// - mem_req/mem_we out 1 each  memory request / write enable
// - mem_addr      out  AWIDTH  memory address
// - mem_wdata     out  DWIDTH  store data
// - mem_rdata     in   DWIDTH  load data, valid with mem_ack
// - mem_ack       in   1       memory completion
// - rf_we, rf_waddr[4:0], rf_wdata[DWIDTH]  out  register-file write port (1-cycle pulse)
// - abs_we, abs_wdata[DWIDTH]              out  abs-register write (1-cycle pulse)
// - regs_clear    out  1       1-cycle pulse clearing game registers
// - flags_out     out  7       architectural flags register
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (stall, mem_*, rf_*, abs_*, regs_clear, flags_out). Async: mem_req drops
//   immediately, in-flight access discarded, no write issued.
// - Opcodes: 0 NOP; 13-17 ABS; 18 LOAD; 19 STORE; all others ALU.
// - FSM IDLE/MEM/WB. Accept only when in_valid && state==IDLE.
// - ALU: next cycle rf_we=1, rf_waddr=rd, rf_wdata=in_data. rd==0 suppresses rf_we (r0 hardwired zero). Latency 1.
// - ABS: next cycle abs_we=1, abs_wdata=in_r_abs; regs_clear=in_reset_regs. No rf write.
// - NOP: no outputs pulse; flags_out unchanged.
// - Every accepted non-NOP: flags_out <= in_flags at same edge as result commit.
// - LOAD/STORE: IDLE->MEM; mem_req=1, mem_we=(STORE), mem_addr, mem_wdata registered, held stable until ack.
//   stall = (state != IDLE). mem_ack sampled only in MEM; ignored elsewhere.
// - MEM + mem_ack: drop mem_req next cycle. LOAD -> WB capturing mem_rdata; WB issues rf_we (rd rule above), ->IDLE.
//   STORE -> IDLE directly. Ack on first MEM cycle legal: LOAD total 3 cycles accept-to-rf_we.
// - Timeout: wait counter resets on entering MEM, increments each MEM cycle without ack; reaching TIMEOUT ->
//   abort: mem_req=0, flags_out[6] set, no rf write, ->IDLE. Ack in the same cycle as count==TIMEOUT wins (no abort).
// - in_valid during stall: not accepted, no side effects. in_valid in WB: stall still high, accepted after IDLE.
// - Pulsed outputs (rf_we, abs_we, regs_clear) are exactly one cycle wide.
// STRUCTURE
// - Shared package: opcode constants (OP_NOP, OP_ABS_LO=13, OP_ABS_HI=17, OP_LOAD=18, OP_STORE=19),
//   field positions, flag bit indices (shared with execute stage), state encoding.
// - One sub-module: mem_wait_timer (counter, clear/enable, expired output, width $clog2(TIMEOUT+1)).
// TESTING
// - Reset: assert rst mid-MEM with mem_req=1 -> mem_req, stall, flags_out 0 same cycle; no rf_we after release.
// - ALU rd=5, in_data=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234; rd=0 -> rf_we stays 0.
// - LOAD addr 0x0040, ack after 3 cycles with rdata=0xCAFE -> mem_req held 3 cycles, stall high, rf_we with 0xCAFE one cycle after ack.
// - STORE in_register=0xBEEF, ack on first MEM cycle -> mem_we=1, wdata=0xBEEF, no rf_we, stall 1 cycle.
// - No ack for TIMEOUT=15 cycles -> mem_req falls, flags_out[6]=1, no rf_we; ack at cycle 15 exactly -> normal completion.
// - ABS opcode 14, in_reset_regs=1, in_r_abs=0x77 -> abs_we, regs_clear one-cycle pulses, abs_wdata=0x77; in_valid during stall ignored.

Source files
------------

// File: rtl/memory_writeback_pkg.sv
// Shared definitions for the memory/writeback stage: opcode map, instruction
// field positions, architectural flag bit indices and FSM state encoding.
package memory_writeback_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;

    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_ABS_LO = 5'd13;
    localparam logic [4:0] OP_ABS_HI = 5'd17;
    localparam logic [4:0] OP_LOAD   = 5'd18;
    localparam logic [4:0] OP_STORE  = 5'd19;

    // Flag vector layout is shared with the execute stage.
    localparam int FLAG_OVERFLOW  = 0;
    localparam int FLAG_ABOVE     = 1;
    localparam int FLAG_EQUAL     = 2;
    localparam int FLAG_BELOW     = 3;
    localparam int FLAG_BETWEEN   = 4;
    localparam int FLAG_COLLISION = 5;
    localparam int FLAG_ERROR     = 6;
    localparam int NUM_FLAGS      = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } wb_state_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ABS   = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_ALU   = 3'd4
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        if (op == OP_NOP)                            cls = CLS_NOP;
        else if (op >= OP_ABS_LO && op <= OP_ABS_HI) cls = CLS_ABS;
        else if (op == OP_LOAD)                      cls = CLS_LOAD;
        else if (op == OP_STORE)                     cls = CLS_STORE;
        else                                         cls = CLS_ALU;
        return cls;
    endfunction

endpackage

// File: rtl/memory_writeback_mem_wait_timer.sv
// Saturating wait counter for outstanding memory requests; o_expired is high
// once the count has reached TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CW-1:0] r_count;

    assign o_expired = (r_count == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable && !o_expired)
            r_count <= r_count + CW'(1);
    end

endmodule

// File: rtl/memory_writeback.sv
// Memory/writeback stage: commits ALU and abs results, runs data-memory
// load/store over a req/ack handshake with timeout, and holds the flags register.
module memory_writeback
    import memory_writeback_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DWIDTH-1:0]    in_data,
    input  logic [DWIDTH-1:0]    in_instr,
    input  logic [DWIDTH-1:0]    in_register,
    input  logic [DWIDTH-1:0]    in_r_abs,
    input  logic [NUM_FLAGS-1:0] in_flags,
    input  logic                 in_reset_regs,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AWIDTH-1:0]    mem_addr,
    output logic [DWIDTH-1:0]    mem_wdata,
    input  logic [DWIDTH-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [DWIDTH-1:0]    rf_wdata,
    output logic                 abs_we,
    output logic [DWIDTH-1:0]    abs_wdata,
    output logic                 regs_clear,
    output logic [NUM_FLAGS-1:0] flags_out,
    output wb_state_t            dbg_state,
    output logic [DWIDTH-1:0]    dbg_last_instr
);

    // Handshake: the execute stage presents in_* with in_valid; a transfer
    // happens on a clock edge where in_valid is high and stall is low. While
    // stall is high nothing on in_* is consumed. Memory side: mem_req and its
    // qualifiers stay constant until the edge that samples mem_ack high.

    wb_state_t           r_state;
    logic [4:0]          r_rd;
    logic                r_is_load;
    logic [NUM_FLAGS-1:0] r_flags;
    logic [DWIDTH-1:0]   r_load_data;

    logic [4:0] w_opcode;
    logic [4:0] w_rd;
    op_class_t  w_class;
    logic       w_expired;
    logic       w_timer_clear;
    logic       w_timer_en;

    assign w_opcode      = in_instr[OPC_MSB:OPC_LSB];
    assign w_rd          = in_instr[RD_MSB:RD_LSB];
    assign w_class       = classify(w_opcode);
    assign w_timer_clear = (r_state != ST_MEM);
    assign w_timer_en    = (r_state == ST_MEM) && !mem_ack;

    assign stall     = (r_state != ST_IDLE);
    assign dbg_state = r_state;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_rd           <= '0;
            r_is_load      <= 1'b0;
            r_flags        <= '0;
            r_load_data    <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            abs_we         <= 1'b0;
            abs_wdata      <= '0;
            regs_clear     <= 1'b0;
            flags_out      <= '0;
            dbg_last_instr <= '0;
        end else begin
            rf_we      <= 1'b0;
            abs_we     <= 1'b0;
            regs_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dbg_last_instr <= in_instr;
                        r_rd           <= w_rd;
                        r_flags        <= in_flags;
                        r_is_load      <= (w_class == CLS_LOAD);
                        case (w_class)
                            CLS_ABS: begin
                                abs_we     <= 1'b1;
                                abs_wdata  <= in_r_abs;
                                regs_clear <= in_reset_regs;
                                flags_out  <= in_flags;
                            end
                            CLS_LOAD, CLS_STORE: begin
                                mem_req   <= 1'b1;
                                mem_we    <= (w_class == CLS_STORE);
                                mem_addr  <= in_data[AWIDTH-1:0];
                                mem_wdata <= in_register;
                                r_state   <= ST_MEM;
                            end
                            CLS_ALU: begin
                                // r0 is hardwired zero, so writes to it are dropped.
                                rf_we     <= (w_rd != 5'd0);
                                rf_waddr  <= w_rd;
                                rf_wdata  <= in_data;
                                flags_out <= in_flags;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MEM: begin
                    // An ack arriving in the expiry cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (r_is_load) begin
                            r_load_data <= mem_rdata;
                            r_state     <= ST_WB;
                        end else begin
                            flags_out <= r_flags;
                            r_state   <= ST_IDLE;
                        end
                    end else if (w_expired) begin
                        mem_req               <= 1'b0;
                        mem_we                <= 1'b0;
                        flags_out[FLAG_ERROR] <= 1'b1;
                        r_state               <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    rf_we     <= (r_rd != 5'd0);
                    rf_waddr  <= r_rd;
                    rf_wdata  <= r_load_data;
                    flags_out <= r_flags;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
